// File: rtl/core_ctrl_fsm.sv
// Multi-cycle fetch/decode/execute/memory sequencer for the RV32I core.
// Drives IR/PC/regfile/memory strobes and keeps cycle/instret counters.
module core_ctrl_fsm #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             is_alu_reg,
    input  logic             is_alu_imm,
    input  logic             is_branch,
    input  logic             is_jal,
    input  logic             is_jalr,
    input  logic             is_lui,
    input  logic             is_auipc,
    input  logic             is_load,
    input  logic             is_store,
    input  logic             is_system,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_wr,
    output logic             addr_sel_data,
    output logic             ir_load,
    output logic             pc_load,
    output logic             reg_write,
    output logic             halted,
    output logic             mem_err,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret_count
);

    // Wait counter only needs to reach MEM_TIMEOUT-1 before the halt fires.
    localparam int unsigned TMO_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_LOAD    = 3'd3,
        S_STORE   = 3'd4,
        S_HALT    = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        C_WB     = 2'd0,
        C_BRANCH = 2'd1,
        C_LOAD   = 2'd2,
        C_STORE  = 2'd3
    } cls_t;

    state_t             r_state;
    cls_t               r_cls;
    logic [TMO_W-1:0]   r_tmo;
    logic               r_mem_err;
    logic [CNT_W-1:0]   r_cycle;
    logic [CNT_W-1:0]   r_instret;

    logic [3:0]         w_flag_cnt;
    logic               w_legal;
    cls_t               w_cls;
    logic               w_tmo_hit;

    // Decoder sanity: exactly one non-SYSTEM class flag must be set.
    always_comb begin
        w_flag_cnt = 4'(is_alu_reg) + 4'(is_alu_imm) + 4'(is_branch)
                   + 4'(is_jal) + 4'(is_jalr) + 4'(is_lui)
                   + 4'(is_auipc) + 4'(is_load) + 4'(is_store);
        w_legal    = !is_system && (w_flag_cnt == 4'd1);
        if (is_load)
            w_cls = C_LOAD;
        else if (is_store)
            w_cls = C_STORE;
        else if (is_branch)
            w_cls = C_BRANCH;
        else
            w_cls = C_WB;
    end

    assign w_tmo_hit = !mem_ready && (r_tmo == TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_cls     <= C_WB;
            r_tmo     <= '0;
            r_mem_err <= 1'b0;
            r_cycle   <= '0;
            r_instret <= '0;
        end else begin
            if (r_state != S_HALT)
                r_cycle <= r_cycle + CNT_W'(1);
            case (r_state)
                S_FETCH, S_LOAD, S_STORE: begin
                    if (mem_ready) begin
                        r_tmo <= '0;
                        if (r_state == S_FETCH) begin
                            r_state <= S_DECODE;
                        end else begin
                            r_instret <= r_instret + CNT_W'(1);
                            r_state   <= S_FETCH;
                        end
                    end else if (w_tmo_hit) begin
                        r_mem_err <= 1'b1;
                        r_state   <= S_HALT;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end
                S_DECODE: begin
                    r_tmo   <= '0;
                    r_cls   <= w_cls;
                    r_state <= w_legal ? S_EXECUTE : S_HALT;
                end
                S_EXECUTE: begin
                    r_tmo <= '0;
                    case (r_cls)
                        C_LOAD:  r_state <= S_LOAD;
                        C_STORE: r_state <= S_STORE;
                        default: begin
                            r_instret <= r_instret + CNT_W'(1);
                            r_state   <= S_FETCH;
                        end
                    endcase
                end
                S_HALT: r_state <= S_HALT;
                default: begin
                    r_tmo   <= '0;
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

    // Strobes decode from state and mem_ready; everything reads 0 during reset.
    always_comb begin
        mem_req       = 1'b0;
        mem_wr        = 1'b0;
        addr_sel_data = 1'b0;
        ir_load       = 1'b0;
        pc_load       = 1'b0;
        reg_write     = 1'b0;
        if (!rst) begin
            case (r_state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    ir_load = mem_ready;
                end
                S_EXECUTE: begin
                    if (r_cls == C_WB || r_cls == C_BRANCH) begin
                        pc_load   = 1'b1;
                        reg_write = (r_cls == C_WB);
                    end
                end
                S_LOAD: begin
                    mem_req       = 1'b1;
                    addr_sel_data = 1'b1;
                    reg_write     = mem_ready;
                    pc_load       = mem_ready;
                end
                S_STORE: begin
                    mem_req       = 1'b1;
                    mem_wr        = 1'b1;
                    addr_sel_data = 1'b1;
                    pc_load       = mem_ready;
                end
                default: ;
            endcase
        end
    end

    assign state         = rst ? 3'd0 : r_state;
    assign halted        = !rst && (r_state == S_HALT);
    assign mem_err       = !rst && r_mem_err;
    assign cycle_count   = rst ? '0 : r_cycle;
    assign instret_count = rst ? '0 : r_instret;

endmodule

// File: doc/core_ctrl_fsm.md
Name: core_ctrl_fsm

Overview:
Multi-cycle sequencer for the RV32I core. It consumes the one-hot opcode-class flags from the instruction decoder and drives the instruction-register, PC, register-file and memory strobes through the fetch/decode/execute/memory phases. It also keeps cycle and retired-instruction counters, and halts on SYSTEM, illegal opcodes or a memory timeout.

Parameters:
CNT_W, 32, width of cycle_count and instret_count
MEM_TIMEOUT, 255, max cycles mem_req may wait for mem_ready before the error halt (>=1)

Ports:
clk  in  1  core clock, all state on rising edge
rst  in  1  synchronous active-high reset
is_alu_reg  in  1  decoder: R-type ALU
is_alu_imm  in  1  decoder: I-type ALU
is_branch  in  1  decoder: conditional branch
is_jal  in  1  decoder: JAL
is_jalr  in  1  decoder: JALR
is_lui  in  1  decoder: LUI
is_auipc  in  1  decoder: AUIPC
is_load  in  1  decoder: load
is_store  in  1  decoder: store
is_system  in  1  decoder: SYSTEM opcode
mem_ready  in  1  memory ack/data-valid for the current request, one-cycle pulse
mem_req  out  1  memory request
mem_wr  out  1  request is a write (valid only with mem_req)
addr_sel_data  out  1  0 = address from PC, 1 = address from ALU (rs1+imm)
ir_load  out  1  capture the fetched word into IR
pc_load  out  1  update PC with next-PC from the datapath
reg_write  out  1  register-file write enable
halted  out  1  core stopped
mem_err  out  1  halt was caused by a memory timeout (sticky)
state  out  3  current state encoding, for debug
cycle_count  out  CNT_W  cycles since reset
instret_count  out  CNT_W  retired instructions

Behaviour:
- States (encoding): FETCH=0, DECODE=1, EXECUTE=2, LOAD=3, STORE=4, HALT=5. Reset → FETCH.
- Reset behaviour: every output is 0 while rst is high, including mem_req. Both counters and the timeout counter clear. A reset mid-request abandons the request; a late mem_ready is ignored.
- Strobes are combinational from state and mem_ready. They are 0 in any state or condition not listed below.
- FETCH: mem_req=1, addr_sel_data=0.
  - On mem_ready: ir_load=1, then go to DECODE.
- DECODE: exactly one cycle, no strobes. This gives the register-file read cycle for the new IR.
  - Count the asserted class flags (excluding is_system).
  - If is_system=1, or the count is not exactly 1: go to HALT (illegal, or SYSTEM treated as stop).
  - Otherwise go to EXECUTE.
- EXECUTE: one cycle, using the flags latched in DECODE (inputs are ignored here).
  - load: go to LOAD. store: go to STORE.
  - Otherwise: pc_load=1, instret +1, go to FETCH.
  - reg_write=1 for alu_reg, alu_imm, lui, auipc, jal, jalr. reg_write=0 for branch (taken/not-taken selection is the datapath's job).
- LOAD: mem_req=1, addr_sel_data=1.
  - On mem_ready: reg_write=1, pc_load=1, instret +1, go to FETCH.
- STORE: mem_req=1, mem_wr=1, addr_sel_data=1.
  - On mem_ready: pc_load=1, instret +1, go to FETCH.
- HALT: halted=1, no strobes, counters frozen. Left only via rst.
- Timeout: a counter clears on entry to FETCH, LOAD or STORE and increments each waiting cycle. If it reaches MEM_TIMEOUT without mem_ready, go to HALT and set mem_err=1.
- Simultaneous events: if mem_ready arrives in the same cycle the timeout would fire, mem_ready wins. mem_ready in DECODE, EXECUTE or HALT is ignored.
- Minimum latency per instruction (mem_ready arriving the same cycle as mem_req):
  - ALU/branch/jump: 3 cycles.
  - Load/store: 4 cycles.
- cycle_count increments every non-reset, non-halted cycle. Both counters wrap modulo 2^CNT_W without flagging.

Test Plan:
- Reset for 2 cycles, then release with mem_ready=1 and is_alu_imm=1 held → state sequence 0,1,2,0. reg_write and pc_load pulse once in EXECUTE (cycle 3). instret_count=1, cycle_count=3.
- Load with mem_ready delayed 3 cycles in LOAD → mem_req=1, addr_sel_data=1 held 4 cycles. reg_write and pc_load are coincident with mem_ready. instret +1.
- Store with immediate ready → mem_wr=1 only in STORE, reg_write never asserts, 4-cycle instruction.
- Branch → pc_load=1 and reg_write=0 in EXECUTE. Next, is_load and is_store both high in DECODE → HALT, halted=1, counters frozen.
- MEM_TIMEOUT=4, mem_ready never arrives in FETCH → HALT after 4 waiting cycles with mem_err=1. A second case with mem_ready on exactly the 4th cycle → DECODE, mem_err=0.
- Preload CNT_W=8 counters near 255 via a long run → both wrap to 0. Assert rst during LOAD with mem_ready arriving the next cycle → state=FETCH, reg_write never pulses.
